seg_display_driver: RTL and testbench
=====================================

// Module: seg_display_driver
// PURPOSE
//  Output end of the 4-bit adder lab datapath; mirrors the switch/button input reader.
//  Time-multiplexes X, Y, Cout and Sum onto a 4-digit common-anode 7-segment display.
//  Inputs are sampled into shadow registers once per scan frame, so no digit tears mid-frame.
//  Sits at top level between the adder outputs and the board's An/Seg/Dp pins.
// PARAMETERS
//  REFRESH_DIV  50000  clock cycles per digit slot (50 MHz -> 1 kHz/digit, 250 Hz frame)
//  BLINK_DIV    25     frames per blink half-period (used only with OVF_BLINK_EN)
// PORTS
//  Clk     in   1  system clock, single clock domain
//  Rst     in   1  synchronous, active-high reset
//  InputX  in   4  adder operand X, shown on digit 3
//  InputY  in   4  adder operand Y, shown on digit 2
//  Sum     in   4  adder sum, shown on digit 0
//  Cout    in   1  adder carry out, shown as 0/1 on digit 1
//  An      out  4  digit anodes, active-low, one-hot-low when lit
//  Seg     out  7  segments {g,f,e,d,c,b,a}, active-low
//  Dp      out  1  decimal point, active-low
// BEHAVIOUR
//  - Reset (sync, next Clk edge; also mid-operation): An=4'b1111, Seg=7'h7F, Dp=1,
//    prescaler=0, digit index=0, all shadow registers=0, blink frame cnt=0, phase=0.
//  - Prescaler counts 0..REFRESH_DIV-1. tick = (prescaler==REFRESH_DIV-1). Prescaler wraps to 0.
//  - On tick, digit index increments mod 4 (3 -> 0 wraps).
//  - Frame start = tick while index==3. On that edge, capture InputX/InputY/Sum/Cout
//    into the shadows. Input changes elsewhere in a frame appear only from the next frame.
//  - The first frame after reset shows shadow zeros ("0000").
//  - An/Seg/Dp are registered from the index and shadows. 1-cycle latency: the index
//    changes at edge N, and An/Seg reflect it at edge N+1.
//  - Digit map (index -> An, value):
//      0 -> 1110, Sum
//      1 -> 1101, {3'b0, Cout}
//      2 -> 1011, InputY
//      3 -> 0111, InputX
//  - Hex decode 0-F, standard active-low patterns; e.g. 0=7'h40, 8=7'h00, F=7'h0E.
//  - Dp=1 (off) on all digits unless the feature below is compiled in.
// CONFIGURATION
//  OVF_BLINK_EN defined:
//  - Frame counter counts 0..BLINK_DIV-1 on frame starts. Phase toggles on its wrap.
//  - While shadow Cout==1 and phase==1, digit 0 outputs Seg=7'h7F (blank); An is unchanged.
//  - Dp=0 on digit 1 whenever shadow Cout==1.
//  - With Cout==0, behaviour matches the undefined case.
//  OVF_BLINK_EN undefined: no frame counter or phase logic, no blanking, Dp constant 1.
// STRUCTURE
//  - seg_display_pkg: hex-to-segment constant table, ANODE_ONEHOT[0:3], SEG_BLANK=7'h7F,
//    digit-index width (2), localparam helpers for counter widths ($clog2).
//  - Sub-module hex_to_seg (combinational 4->7 decoder), one instance on the muxed nibble.
//  - Top holds the prescaler, index counter, shadows, blink logic and output registers.
// TESTING (bench uses REFRESH_DIV=4, BLINK_DIV=2)
//  1. Assert Rst 3 cycles, then release -> An=1111, Seg=7F, Dp=1 until the first registered
//     update; then An=1110 with Seg=7'h40.
//  2. X=3, Y=5, Sum=8, Cout=0, run 2 frames -> second frame digits 3..0 show 3,5,0,8:
//     Seg 7'h30, 7'h12, 7'h40, 7'h00; each An slot held exactly 4 cycles.
//  3. Change X from 3 to A mid-frame -> digit 3 keeps showing 3 until the next frame start,
//     then shows 7'h08.
//  4. Assert Rst on a cycle where index==2 -> next edge gives An=1111 and index=0;
//     the prescaler restarts from 0.
//  5. Index wrap check -> An sequence 1110,1101,1011,0111,1110, with no two digits ever low together.
//  6. OVF_BLINK_EN, X=F, Y=1, Sum=0, Cout=1 -> digit 1 shows 1 with Dp=0; digit 0 alternates
//     between 7'h40 and 7'h7F every 2 frames. Same test without the macro -> no blank, Dp=1.

Source files
------------

// File: rtl/seg_display_pkg.sv
//------------------------------------------------------------------------------
// Module   : seg_display_pkg
// Brief    : Shared constants for the 4-digit 7-segment display driver.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package seg_display_pkg;

    localparam int IDX_W = 2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low anode per digit index
    localparam logic [3:0] ANODE_ONEHOT [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Active-low {g,f,e,d,c,b,a} for hex digits 0..F
    localparam logic [6:0] HEX_SEG [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hex_to_seg.sv
//------------------------------------------------------------------------------
// Module   : hex_to_seg
// Brief    : Combinational hex nibble to active-low 7-segment decoder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hex_to_seg
    import seg_display_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG[i_hex];

endmodule

`default_nettype wire

// File: rtl/seg_display_driver.sv
//------------------------------------------------------------------------------
// Module   : seg_display_driver
// Brief    : Scans X, Y, Cout and Sum onto a 4-digit common-anode display,
//            with inputs latched once per frame. Optional macro OVF_BLINK_EN
//            blinks digit 0 and lights digit 1's point on carry out.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg_display_driver
    import seg_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 25
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] InputX,
    input  logic [3:0] InputY,
    input  logic [3:0] Sum,
    input  logic       Cout,
    output logic [3:0] An,
    output logic [6:0] Seg,
    output logic       Dp
);

    localparam int c_PRE_W = cnt_w(REFRESH_DIV);

    logic [c_PRE_W-1:0] r_pre;
    logic [IDX_W-1:0]   r_idx;
    logic [3:0]         r_sh_x, r_sh_y, r_sh_sum;
    logic               r_sh_cout;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;
    logic               r_dp;

    logic               w_tick;
    logic               w_frame_start;
    logic [3:0]         w_nib;
    logic [6:0]         w_seg_dec;
    logic               w_blank;
    logic               w_dp;

    assign w_tick        = (r_pre == c_PRE_W'(REFRESH_DIV - 1));
    assign w_frame_start = w_tick && (r_idx == IDX_W'(3));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_pre     <= '0;
            r_idx     <= '0;
            r_sh_x    <= '0;
            r_sh_y    <= '0;
            r_sh_sum  <= '0;
            r_sh_cout <= 1'b0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
                r_idx <= r_idx + 1'b1;
            end
            // Shadows refresh only at frame boundaries so a frame never tears
            if (w_frame_start) begin
                r_sh_x    <= InputX;
                r_sh_y    <= InputY;
                r_sh_sum  <= Sum;
                r_sh_cout <= Cout;
            end
        end
    end

    always_comb begin
        w_nib = r_sh_sum;
        case (r_idx)
            2'd0:    w_nib = r_sh_sum;
            2'd1:    w_nib = {3'b000, r_sh_cout};
            2'd2:    w_nib = r_sh_y;
            default: w_nib = r_sh_x;
        endcase
    end

    hex_to_seg u_dec (
        .i_hex (w_nib),
        .o_seg (w_seg_dec)
    );

`ifdef OVF_BLINK_EN
    localparam int c_FRM_W = cnt_w(BLINK_DIV);

    logic [c_FRM_W-1:0] r_frm;
    logic               r_phase;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_frm   <= '0;
            r_phase <= 1'b0;
        end else if (w_frame_start) begin
            if (r_frm == c_FRM_W'(BLINK_DIV - 1)) begin
                r_frm   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_frm <= r_frm + 1'b1;
            end
        end
    end

    assign w_blank = r_sh_cout && r_phase && (r_idx == IDX_W'(0));
    assign w_dp    = ~(r_sh_cout && (r_idx == IDX_W'(1)));
`else
    assign w_blank = 1'b0;
    assign w_dp    = 1'b1;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_an  <= 4'b1111;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= ANODE_ONEHOT[r_idx];
            r_seg <= w_blank ? SEG_BLANK : w_seg_dec;
            r_dp  <= w_dp;
        end
    end

    assign An  = r_an;
    assign Seg = r_seg;
    assign Dp  = r_dp;

endmodule

`default_nettype wire

// File: tb/tb_seg_display_driver.sv
//------------------------------------------------------------------------------
// Module   : tb_seg_display_driver
// Brief    : Directed self-checking bench for seg_display_driver
//            (REFRESH_DIV=4, BLINK_DIV=2; honours OVF_BLINK_EN).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seg_display_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] x, y, sum;
    logic       cout;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int cyc;
    int n_pass;
    int n_total;

    logic [3:0] an_tab [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

`ifdef OVF_BLINK_EN
    logic blink_en = 1'b1;
`else
    logic blink_en = 1'b0;
`endif

    always #5 clk = ~clk;

    seg_display_driver #(
        .REFRESH_DIV (4),
        .BLINK_DIV   (2)
    ) dut (
        .Clk    (clk),
        .Rst    (rst),
        .InputX (x),
        .InputY (y),
        .Sum    (sum),
        .Cout   (cout),
        .An     (an),
        .Seg    (seg),
        .Dp     (dp)
    );

    // cyc counts active edges since reset release; sampling is 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; x = 4'h0; y = 4'h0; sum = 4'h0; cout = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        cyc = 0;
        n_total++; if (an !== 4'b1111) $display("FAIL reset_an got %b want 1111", an); else n_pass++;
        n_total++; if (seg !== 7'h7F) $display("FAIL reset_seg got %h want 7f", seg); else n_pass++;
        n_total++; if (dp !== 1'b1) $display("FAIL reset_dp got %b want 1", dp); else n_pass++;
        // Inputs for the next test, captured at the first frame start
        x = 4'h3; y = 4'h5; sum = 4'h8; cout = 1'b0;
        step();
        n_total++; if (an !== 4'b1110) $display("FAIL first_an got %b want 1110", an); else n_pass++;
        n_total++; if (seg !== 7'h40) $display("FAIL first_seg got %h want 40", seg); else n_pass++;
    endtask

    task automatic test_frame();
        logic [6:0] seg_tab [0:3];
        seg_tab = '{7'h00, 7'h40, 7'h12, 7'h30};
        step_to(16);
        for (int c = 17; c <= 32; c++) begin
            int s;
            step();
            s = (c - 1) / 4 % 4;
            n_total++; if (an !== an_tab[s]) $display("FAIL frame_an c=%0d got %b want %b", c, an, an_tab[s]); else n_pass++;
            n_total++; if (seg !== seg_tab[s]) $display("FAIL frame_seg c=%0d got %h want %h", c, seg, seg_tab[s]); else n_pass++;
            n_total++; if (dp !== 1'b1) $display("FAIL frame_dp c=%0d got %b want 1", c, dp); else n_pass++;
        end
    endtask

    task automatic test_mid_frame();
        step_to(40);
        x = 4'hA;
        step_to(45);
        n_total++; if (an !== 4'b0111) $display("FAIL mid_an got %b want 0111", an); else n_pass++;
        n_total++; if (seg !== 7'h30) $display("FAIL mid_hold got %h want 30", seg); else n_pass++;
        step_to(61);
        n_total++; if (an !== 4'b0111) $display("FAIL next_an got %b want 0111", an); else n_pass++;
        n_total++; if (seg !== 7'h08) $display("FAIL next_seg got %h want 08", seg); else n_pass++;
    endtask

    task automatic test_reset_mid();
        step_to(73);
        n_total++; if (an !== 4'b1011) $display("FAIL pre_rst_an got %b want 1011", an); else n_pass++;
        rst = 1'b1;
        step();
        n_total++; if (an !== 4'b1111) $display("FAIL midrst_an got %b want 1111", an); else n_pass++;
        n_total++; if (seg !== 7'h7F) $display("FAIL midrst_seg got %h want 7f", seg); else n_pass++;
        rst = 1'b0;
        cyc = 0;
        step();
        n_total++; if (an !== 4'b1110) $display("FAIL rst_idx0_an got %b want 1110", an); else n_pass++;
        n_total++; if (seg !== 7'h40) $display("FAIL rst_shadow_seg got %h want 40", seg); else n_pass++;
        step_to(4);
        n_total++; if (an !== 4'b1110) $display("FAIL rst_pre_an got %b want 1110", an); else n_pass++;
        step();
        n_total++; if (an !== 4'b1101) $display("FAIL rst_pre_adv got %b want 1101", an); else n_pass++;
    endtask

    task automatic test_wrap();
        for (int c = 6; c <= 36; c++) begin
            int s;
            step();
            s = (c - 1) / 4 % 4;
            n_total++; if (an !== an_tab[s]) $display("FAIL wrap_an c=%0d got %b want %b", c, an, an_tab[s]); else n_pass++;
            n_total++; if ($countones(~an) != 1) $display("FAIL wrap_onehot c=%0d got %b want one low", c, an); else n_pass++;
        end
    endtask

    task automatic test_blink();
        rst = 1'b1;
        x = 4'hF; y = 4'h1; sum = 4'h0; cout = 1'b1;
        step();
        rst = 1'b0;
        cyc = 0;
        for (int m = 1; m <= 5; m++) begin
            logic [6:0] e_seg;
            logic       e_dp;
            e_seg = (blink_en && ((m / 2) % 2 == 1)) ? 7'h7F : 7'h40;
            e_dp  = ~blink_en;
            step_to(16 * m + 1);
            n_total++; if (an !== 4'b1110) $display("FAIL blink_an m=%0d got %b want 1110", m, an); else n_pass++;
            n_total++; if (seg !== e_seg) $display("FAIL blink_seg m=%0d got %h want %h", m, seg, e_seg); else n_pass++;
            step_to(16 * m + 5);
            n_total++; if (an !== 4'b1101) $display("FAIL cout_an m=%0d got %b want 1101", m, an); else n_pass++;
            n_total++; if (seg !== 7'h79) $display("FAIL cout_seg m=%0d got %h want 79", m, seg); else n_pass++;
            n_total++; if (dp !== e_dp) $display("FAIL cout_dp m=%0d got %b want %b", m, dp, e_dp); else n_pass++;
            step_to(16 * m + 9);
            n_total++; if (seg !== 7'h79) $display("FAIL y_seg m=%0d got %h want 79", m, seg); else n_pass++;
            n_total++; if (dp !== 1'b1) $display("FAIL y_dp m=%0d got %b want 1", m, dp); else n_pass++;
            step_to(16 * m + 13);
            n_total++; if (seg !== 7'h0E) $display("FAIL x_seg m=%0d got %h want 0e", m, seg); else n_pass++;
        end
    endtask

    initial begin
        cyc = 0; n_pass = 0; n_total = 0;
        test_reset();
        test_frame();
        test_mid_frame();
        test_reset_mid();
        test_wrap();
        test_blink();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
